ctrl_escritura_br: RTL

- Write-port controller and scoreboard for the 16x32 register bank, which has one write port and two asynchronous read ports.
- Shares the single write port between two writeback requesters, ALU and MEM, using valid/ready handshakes and round-robin arbitration.
- Tracks a per-register "pending write" bit set by the issue stage and raises a read-hazard stall.
- Sits between decode/issue, the execute/memory writeback paths and the register bank's WE/WA/DW inputs.

---
 rtl/ctrl_escritura_br_pkg.sv | 44 ++++
 rtl/ctrl_escritura_br_if.sv | 43 ++++
 rtl/ctrl_escritura_br_arb_rr2.sv | 33 +++
 rtl/ctrl_escritura_br.sv | 111 +++++++++++
 4 files changed

// File: rtl/ctrl_escritura_br_pkg.sv
// pkg_br: shared constants, requester encoding, writeback request type and
// small helpers for the register-bank write controller.
//   NREG : implemented registers (addresses 0..NREG-1)
//   AW   : register address width
//   DW   : data width
package pkg_br;

  localparam int NREG = 16;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int IW   = $clog2(NREG);

  // Requester index; also the encoding of the round-robin pointer.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_idx_e;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

  function automatic logic en_rango(input logic [AW-1:0] a);
    return (a < AW'(NREG));
  endfunction

  // Busy lookup that treats out-of-range addresses as "not busy".
  function automatic logic bit_busy(input logic [NREG-1:0] busy, input logic [AW-1:0] a);
    logic r;
    if (en_rango(a)) r = busy[a[IW-1:0]];
    else             r = 1'b0;
    return r;
  endfunction

  function automatic logic [AW-1:0] popcount(input logic [NREG-1:0] v);
    logic [AW-1:0] c;
    c = {AW{1'b0}};
    for (int i = 0; i < NREG; i++) c = c + {{(AW-1){1'b0}}, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/ctrl_escritura_br_if.sv
// ctrl_escritura_br_if: bundle of the reservation, hazard-check, writeback
// and register-bank write signals around the write controller.
//   master : pipeline/bank side (drives requests, observes ready/we/flags)
//   slave  : the controller
interface ctrl_escritura_br_if;
  import pkg_br::*;

  logic          res_valid;
  logic [AW-1:0] res_addr;
  logic          res_ready;
  logic [AW-1:0] chk_a1;
  logic [AW-1:0] chk_a2;
  logic          stall;
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] dw;
  logic [AW-1:0] pend_cnt;
  logic          err_rango;
  logic          err_noreserva;

  modport master (
    output res_valid, res_addr, chk_a1, chk_a2,
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  res_ready, stall, alu_ready, mem_ready,
    input  we, wa, dw, pend_cnt, err_rango, err_noreserva
  );

  modport slave (
    input  res_valid, res_addr, chk_a1, chk_a2,
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output res_ready, stall, alu_ready, mem_ready,
    output we, wa, dw, pend_cnt, err_rango, err_noreserva
  );

endinterface

// File: rtl/ctrl_escritura_br_arb_rr2.sv
// arb_rr2: two-way round-robin arbiter with combinational grant.
//   clk, rst : clock, async active-high reset (pointer -> ALU)
//   i_req    : {mem, alu} requests
//   o_gnt    : {mem, alu} one-hot grant (or zero)
module arb_rr2 import pkg_br::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  req_idx_e r_ptr;

  // Grant: a lone requester wins; on contention the pointer decides.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_ptr == REQ_ALU) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Pointer: after any grant, favour the requester that was not served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_ptr <= REQ_ALU;
    else if (o_gnt[0]) r_ptr <= REQ_MEM;
    else if (o_gnt[1]) r_ptr <= REQ_ALU;
    else               r_ptr <= r_ptr;
  end

endmodule

// File: rtl/ctrl_escritura_br.sv
// ctrl_escritura_br: write-port controller and pending-write scoreboard for
// the 16x32 register bank.
//   clk, rst : clock, async active-high reset
//   bus      : reservation (res_*), hazard check (chk_a*, stall), ALU/MEM
//              writeback handshakes, registered bank write (we/wa/dw),
//              pend_cnt and sticky error flags.
module ctrl_escritura_br import pkg_br::*; (
  input logic               clk,
  input logic               rst,
  ctrl_escritura_br_if.slave bus
);

  logic [NREG-1:0] r_busy;
  logic            r_we;
  logic [AW-1:0]   r_wa;
  logic [DW-1:0]   r_dw;
  logic [AW-1:0]   r_pend_cnt;
  logic            r_err_rango;
  logic            r_err_noreserva;

  wb_req_t         w_alu;
  wb_req_t         w_mem;
  wb_req_t         w_sel;
  logic [1:0]      w_gnt;
  logic            w_res_ok;
  logic            w_sel_busy;
  logic [NREG-1:0] w_busy_nxt;

  assign w_alu = '{valid: bus.alu_valid, addr: bus.alu_addr, data: bus.alu_data};
  assign w_mem = '{valid: bus.mem_valid, addr: bus.mem_addr, data: bus.mem_data};

  arb_rr2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req ({w_mem.valid, w_alu.valid}),
    .o_gnt (w_gnt)
  );

  // Granted request, reservation acceptance and next busy vector.
  always_comb begin
    w_sel = '0;
    if (w_gnt[0])      w_sel = w_alu;
    else if (w_gnt[1]) w_sel = w_mem;
    else               w_sel = '0;
    w_sel_busy = bit_busy(r_busy, w_sel.addr);
    // Out-of-range reservations are accepted so the error gets flagged.
    w_res_ok = bus.res_valid & (~en_rango(bus.res_addr) | ~bit_busy(r_busy, bus.res_addr));
    w_busy_nxt = r_busy;
    // Clear before set: a same-address reservation is refused anyway
    // (busy was 1), and an unreserved write must not undo a new reservation.
    if (w_sel.valid && en_rango(w_sel.addr)) w_busy_nxt[w_sel.addr[IW-1:0]] = 1'b0;
    else                                     w_busy_nxt = w_busy_nxt;
    if (w_res_ok && en_rango(bus.res_addr))  w_busy_nxt[bus.res_addr[IW-1:0]] = 1'b1;
    else                                     w_busy_nxt = w_busy_nxt;
  end

  // Scoreboard state and its popcount, updated together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= {NREG{1'b0}};
      r_pend_cnt <= {AW{1'b0}};
    end else begin
      r_busy     <= w_busy_nxt;
      r_pend_cnt <= popcount(w_busy_nxt);
    end
  end

  // Bank write port: only a write to a reserved register raises we.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we <= 1'b0;
      r_wa <= {AW{1'b0}};
      r_dw <= {DW{1'b0}};
    end else if (w_sel.valid) begin
      r_we <= w_sel_busy;
      r_wa <= w_sel.addr;
      r_dw <= w_sel.data;
    end else begin
      r_we <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_rango     <= 1'b0;
      r_err_noreserva <= 1'b0;
    end else begin
      if ((w_sel.valid && !en_rango(w_sel.addr)) || (w_res_ok && !en_rango(bus.res_addr)))
        r_err_rango <= 1'b1;
      else
        r_err_rango <= r_err_rango;
      if (w_sel.valid && en_rango(w_sel.addr) && !w_sel_busy)
        r_err_noreserva <= 1'b1;
      else
        r_err_noreserva <= r_err_noreserva;
    end
  end

  assign bus.res_ready     = w_res_ok;
  assign bus.stall         = bit_busy(r_busy, bus.chk_a1) | bit_busy(r_busy, bus.chk_a2);
  assign bus.alu_ready     = w_gnt[0];
  assign bus.mem_ready     = w_gnt[1];
  assign bus.we            = r_we;
  assign bus.wa            = r_wa;
  assign bus.dw            = r_dw;
  assign bus.pend_cnt      = r_pend_cnt;
  assign bus.err_rango     = r_err_rango;
  assign bus.err_noreserva = r_err_noreserva;

endmodule
